shift_line_taps: RTL
====================

Name: shift_line_taps

Overview:
Parametrised line buffer that holds the last TAPS-1 image lines and presents a vertical column of TAPS pixels (current line plus up to TAPS-1 previous lines at the same column) for 2-D window filters such as 3x3 and 5x5 convolution/Sobel. It generalises the fixed 3-row tap shifter with configurable line length and tap count, start-of-frame restart, masking of unfilled rows, and a window-valid flag. It sits between the pixel source and the window/kernel stage.

Parameters:
DATA_WIDTH, 8, pixel width in bits
LINE_WIDTH, 128, pixels per line; must be >= 2
TAPS, 3, rows presented; must be >= 2
COL_W, $clog2(LINE_WIDTH), column counter width (derived, not overridden)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
clken  input  1  pixel strobe; one pixel accepted per cycle when high
sof  input  1  start of frame, sampled only with clken; marks the pixel as column 0 of line 0
shiftin  input  DATA_WIDTH  incoming pixel
taps  output  TAPS*DATA_WIDTH  taps[k*DATA_WIDTH +: DATA_WIDTH] = pixel k lines above the current one at the same column; k=0 is the current pixel
taps_valid  output  1  one-cycle pulse; taps holds a complete column (all TAPS rows real)
col_idx  output  COL_W  column of the pixel currently on taps
row_fill  output  $clog2(TAPS)+1  lines completed since sof, saturating at TAPS-1

Behaviour:
- Reset (rst=1 at posedge): taps=0, taps_valid=0, col_idx=0, row_fill=0, internal column pointer=0. Storage memory is not cleared; stale content is masked (see below).
- Storage: LINE_WIDTH-deep memory, word width (TAPS-1)*DATA_WIDTH; word[c] holds rows 1..TAPS-1 for column c. Read-before-write at the same address in one cycle. RAM inference is permitted.
- Per cycle with clken=1, where c is the column pointer (0 if sof=1) and f is the fill count (0 if sof=1):
  - taps <= {masked word[c], shiftin}. Row k (k>=1) is forced to 0 when k > f.
  - word[c] <= {word[c] rows 1..TAPS-2, shiftin}. The oldest row is dropped.
  - taps_valid <= (f >= TAPS-1). col_idx <= c.
  - Pointer: if c == LINE_WIDTH-1, it becomes 0 and row_fill <= min(f+1, TAPS-1); otherwise it becomes c+1.
- Latency: 1 cycle from the clken edge to the taps update.
- With clken=0: taps, col_idx, row_fill and the pointer hold; taps_valid <= 0; memory is not written. sof is ignored.
- sof mid-line or mid-frame: the pointer restarts at 0 and the fill count at 0 on that pixel. Previous-line data is masked to 0 until it is rewritten, so no stale rows ever appear.
- rst together with clken: rst wins and the pixel is discarded.
- Line wrap: column LINE_WIDTH-1 is followed by column 0 with no bubble. row_fill saturates and never wraps.
- No backpressure; the source must not depend on taps_valid.

Test Plan:
- LINE_WIDTH=4, TAPS=3; rst, then sof + ramp 0..15 with continuous clken -> taps_valid first high on the cycle after pixel 8. taps then = {rows 2,1,0} = {0,4,8}, col_idx=0, row_fill=2. On the next cycle, {1,5,9}.
- Same stream, check pixel 5 -> taps={0 (masked),1,5}, taps_valid=0, row_fill=1.
- Random clken gaps (~50% duty) on the ramp -> taps sequence identical to the continuous run and only updates after a clken cycle. taps_valid never high on a cycle following clken=0.
- Fill two lines, then sof at column 2 with pixel 100 -> taps={0,0,100}, col_idx=0, row_fill=0. No old-frame value appears until new rows are written.
- Assert rst at pixel 10 with clken=1 -> next cycle all outputs are 0. The following sof + pixel 7 gives taps={0,0,7}.
- TAPS=5, LINE_WIDTH=8, 6 lines of ramp -> row_fill saturates at 4. The first valid occurs on pixel 32, with taps={0,8,16,24,32}.

Source files
------------

// File: rtl/shift_line_taps.sv
// Line buffer that presents a vertical column of TAPS pixels (current line plus
// up to TAPS-1 previous lines at the same column) for 2-D window filters.
// Rows of the column that have not been written since the last start of frame
// are forced to zero, so stale lines never reach the window stage.
module shift_line_taps #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 128,
  parameter int TAPS       = 3,
  parameter int COL_W      = $clog2(LINE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clken,
  input  logic                       sof,
  input  logic [DATA_WIDTH-1:0]      shiftin,
  output logic [TAPS*DATA_WIDTH-1:0] taps,
  output logic                       taps_valid,
  output logic [COL_W-1:0]           col_idx,
  output logic [$clog2(TAPS):0]      row_fill
);

  localparam int FILL_W = $clog2(TAPS) + 1;
  localparam int WORD_W = (TAPS - 1) * DATA_WIDTH;
  localparam logic [COL_W-1:0]  LastCol = COL_W'(LINE_WIDTH - 1);
  localparam logic [FILL_W-1:0] MaxFill = FILL_W'(TAPS - 1);

  // word[c] holds rows 1..TAPS-1 of column c, row 1 in the least significant slot
  logic [WORD_W-1:0] mem [LINE_WIDTH];

  logic [COL_W-1:0]  ptr_q, ptr_d, col_eff;
  logic [FILL_W-1:0] fill_q, fill_d, fill_eff;
  logic [WORD_W-1:0] rd_word, rd_masked, wr_word;

  // Effective column/fill for this pixel, row masking and next pointer/fill
  always_comb begin
    col_eff   = sof ? '0 : ptr_q;
    fill_eff  = sof ? '0 : fill_q;
    rd_word   = mem[col_eff];
    rd_masked = '0;
    for (int k = 1; k < TAPS; k++) begin
      // Row k is real only once k lines of this frame have been completed
      if (FILL_W'(k) <= fill_eff) begin
        rd_masked[(k-1)*DATA_WIDTH +: DATA_WIDTH] = rd_word[(k-1)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (col_eff == LastCol) begin
      ptr_d  = '0;
      fill_d = (fill_eff >= MaxFill) ? MaxFill : fill_eff + FILL_W'(1);
    end else begin
      ptr_d  = col_eff + COL_W'(1);
      fill_d = fill_eff;
    end
  end

  // New word: every row moves one line older, the oldest row drops out
  if (TAPS > 2) begin : g_shift
    assign wr_word = {rd_word[WORD_W-DATA_WIDTH-1:0], shiftin};
  end else begin : g_single
    assign wr_word = shiftin;
  end

  // Line storage; read-before-write, never cleared (masking hides stale content)
  always_ff @(posedge clk) begin
    if (clken && !rst) begin
      mem[col_eff] <= wr_word;
    end
  end

  // Output column, flags and column/fill state
  always_ff @(posedge clk) begin
    if (rst) begin
      taps       <= '0;
      taps_valid <= 1'b0;
      col_idx    <= '0;
      ptr_q      <= '0;
      fill_q     <= '0;
    end else if (clken) begin
      taps       <= {rd_masked, shiftin};
      taps_valid <= (fill_eff >= MaxFill);
      col_idx    <= col_eff;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
    end else begin
      taps_valid <= 1'b0;
    end
  end

  assign row_fill = fill_q;

endmodule
